// File: rtl/ofdm_cp_strip.sv
// CP removal / FFT windowing front end: skips the cyclic prefix less a run-time advance, emits
// FFT_LEN-sample windows tagged with {meta, advance used}, and re-aligns on SSB start pulses.
module ofdm_cp_strip #(
    parameter int unsigned IN_DW  = 32,
    parameter int unsigned NFFT   = 8,
    parameter int unsigned NUM_CH = 1,
    parameter int unsigned META_W = 22,
    parameter int unsigned CP_W   = $clog2(20 * (2 ** NFFT) / 256 + 1)
) (
    input  logic                       clk_i,
    input  logic                       reset_ni,
    input  logic [NUM_CH*IN_DW-1:0]    s_axis_in_tdata,
    input  logic [META_W+CP_W-1:0]     s_axis_in_tuser,
    input  logic                       s_axis_in_tlast,
    input  logic                       s_axis_in_tvalid,
    input  logic [CP_W-1:0]            cp_advance_i,
    input  logic                       SSB_start_i,
    output logic [NUM_CH*IN_DW-1:0]    m_axis_out_tdata,
    output logic [META_W+CP_W-1:0]     m_axis_out_tuser,
    output logic                       m_axis_out_tlast,
    output logic                       m_axis_out_tvalid,
    output logic                       trunc_o,
    output logic                       jump_fwd_o,
    output logic                       jump_bwd_o
);
    localparam int unsigned DW = NUM_CH * IN_DW;
    localparam int unsigned UW = META_W + CP_W;

    typedef enum logic [1:0] {
        SKIP_CP  = 2'd0,
        PROCESS  = 2'd1,
        SKIP_END = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [CP_W-1:0]   cp_cnt_q, cp_cnt_d;
    logic [CP_W-1:0]   adv_q, adv_d;
    logic [NFFT-1:0]   in_cnt_q, in_cnt_d;
    logic [DW-1:0]     tdata_q, tdata_d;
    logic [UW-1:0]     tuser_q, tuser_d;
    logic              tlast_q, tlast_d;
    logic              tvalid_q, tvalid_d;
    logic              trunc_q, trunc_d;
    logic              fwd_q, fwd_d;
    logic              bwd_q, bwd_d;

    logic [CP_W-1:0]   cp_len, adv_clamp, adv_eff, cnt_eff, skip_len;
    logic [META_W-1:0] meta;
    logic [NFFT-1:0]   in_eff;
    logic              restart, in_cp;
    logic              proc;

    // Beat decode: an SSB pulse restarts CP counting unless the window is running or tlast closes the symbol.
    always_comb begin
        cp_len    = s_axis_in_tuser[CP_W-1:0];
        meta      = s_axis_in_tuser[UW-1:CP_W];
        adv_clamp = (cp_advance_i > cp_len) ? cp_len : cp_advance_i;
        restart   = SSB_start_i && ((state_q == SKIP_CP) ||
                    ((state_q == SKIP_END) && !(s_axis_in_tvalid && s_axis_in_tlast)));
        in_cp     = (state_q == SKIP_CP) || restart;
        cnt_eff   = SSB_start_i ? '0 : cp_cnt_q;
        adv_eff   = (cnt_eff == '0) ? adv_clamp : adv_q;
        skip_len  = cp_len - adv_eff;
        in_eff    = (state_q == PROCESS) ? in_cnt_q : '0;
    end

    always_comb begin
        state_d  = state_q;
        cp_cnt_d = cp_cnt_q;
        adv_d    = adv_q;
        in_cnt_d = in_cnt_q;
        tdata_d  = '0;
        tuser_d  = tuser_q;
        tlast_d  = 1'b0;
        tvalid_d = 1'b0;
        trunc_d  = 1'b0;
        fwd_d    = 1'b0;
        bwd_d    = 1'b0;
        proc     = 1'b0;

        if (restart) begin
            state_d  = SKIP_CP;
            cp_cnt_d = '0;
            bwd_d    = (state_q == SKIP_CP) && (cp_cnt_q != '0);
            fwd_d    = (state_q == SKIP_END);
        end

        if (s_axis_in_tvalid) begin
            if (in_cp) begin
                if (cnt_eff == '0) begin
                    adv_d = adv_clamp;
                end
                if (skip_len == '0) begin
                    proc = 1'b1;
                end else if (cnt_eff == skip_len - CP_W'(1)) begin
                    state_d  = PROCESS;
                    cp_cnt_d = '0;
                    in_cnt_d = '0;
                end else begin
                    cp_cnt_d = cnt_eff + CP_W'(1);
                end
            end else if (state_q == PROCESS) begin
                proc = 1'b1;
            end else if (s_axis_in_tlast) begin
                state_d  = SKIP_CP;
                cp_cnt_d = '0;
            end
        end

        // Window beat: forward data, tag on the first beat, close on full length or early tlast.
        if (proc) begin
            tvalid_d = 1'b1;
            tdata_d  = s_axis_in_tdata;
            if (in_eff == '0) begin
                tuser_d = {meta, in_cp ? adv_clamp : adv_q};
            end
            if (in_eff == '1) begin
                tlast_d  = 1'b1;
                state_d  = s_axis_in_tlast ? SKIP_CP : SKIP_END;
                cp_cnt_d = '0;
            end else if (s_axis_in_tlast) begin
                tlast_d  = 1'b1;
                trunc_d  = 1'b1;
                state_d  = SKIP_CP;
                cp_cnt_d = '0;
            end else begin
                state_d  = PROCESS;
                in_cnt_d = in_eff + NFFT'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q  <= SKIP_CP;
            cp_cnt_q <= '0;
            adv_q    <= '0;
            in_cnt_q <= '0;
            tdata_q  <= '0;
            tuser_q  <= '0;
            tlast_q  <= 1'b0;
            tvalid_q <= 1'b0;
            trunc_q  <= 1'b0;
            fwd_q    <= 1'b0;
            bwd_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cp_cnt_q <= cp_cnt_d;
            adv_q    <= adv_d;
            in_cnt_q <= in_cnt_d;
            tdata_q  <= tdata_d;
            tuser_q  <= tuser_d;
            tlast_q  <= tlast_d;
            tvalid_q <= tvalid_d;
            trunc_q  <= trunc_d;
            fwd_q    <= fwd_d;
            bwd_q    <= bwd_d;
        end
    end

    assign m_axis_out_tdata  = tdata_q;
    assign m_axis_out_tuser  = tuser_q;
    assign m_axis_out_tlast  = tlast_q;
    assign m_axis_out_tvalid = tvalid_q;
    assign trunc_o           = trunc_q;
    assign jump_fwd_o        = fwd_q;
    assign jump_bwd_o        = bwd_q;

endmodule

// File: tb/tb_ofdm_cp_strip.sv
// Bench for ofdm_cp_strip: scenario table with hand-derived window expectations plus a
// per-beat reference built from symbol/window interval arithmetic, with random gaps and data.
module tb_ofdm_cp_strip;
    localparam int unsigned IN_DW  = 32;
    localparam int unsigned NFFT   = 8;
    localparam int unsigned NUM_CH = 2;
    localparam int unsigned META_W = 22;
    localparam int unsigned CP_W   = 5;
    localparam int unsigned DW     = NUM_CH * IN_DW;
    localparam int unsigned UW     = META_W + CP_W;
    localparam int          FFT_LEN = 256;

    typedef struct {
        int cp_len, adv_a, adv_b, nsym, gap_pct, trunc_sym, trunc_len, ssb_sym, ssb_off;
        int exp_nwin, exp_ws0, exp_adv0, exp_ws1, exp_adv1, exp_trunc, exp_fwd, exp_bwd;
    } vec_t;

    typedef struct {
        logic [DW-1:0]     data;
        logic [META_W-1:0] meta;
        int                cp_len;
        int                adv;
        logic              tlast;
        logic              ssb;
    } beat_t;

    typedef struct {
        bit            v, last, trunc, fwd, bwd;
        logic [UW-1:0] tuser;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] s_tdata, m_tdata;
    logic [UW-1:0] s_tuser, m_tuser;
    logic          s_tlast, s_tvalid, ssb;
    logic [CP_W-1:0] adv_i;
    logic          m_tlast, m_tvalid, trunc, jfwd, jbwd;

    beat_t beats[$];
    exp_t  ex[];
    vec_t  vt[11];
    int    n_tests = 0;
    int    n_fail  = 0;

    always #5 clk = ~clk;

    ofdm_cp_strip #(.IN_DW(IN_DW), .NFFT(NFFT), .NUM_CH(NUM_CH), .META_W(META_W), .CP_W(CP_W)) dut (
        .clk_i(clk), .reset_ni(rst_n),
        .s_axis_in_tdata(s_tdata), .s_axis_in_tuser(s_tuser), .s_axis_in_tlast(s_tlast),
        .s_axis_in_tvalid(s_tvalid), .cp_advance_i(adv_i), .SSB_start_i(ssb),
        .m_axis_out_tdata(m_tdata), .m_axis_out_tuser(m_tuser), .m_axis_out_tlast(m_tlast),
        .m_axis_out_tvalid(m_tvalid), .trunc_o(trunc), .jump_fwd_o(jfwd), .jump_bwd_o(jbwd)
    );

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    task automatic drive_idle();
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        ssb      = 1'b0;
    endtask

    task automatic drive_beat(input beat_t b);
        s_tvalid = 1'b1;
        s_tdata  = b.data;
        s_tuser  = {b.meta, CP_W'(b.cp_len)};
        s_tlast  = b.tlast;
        ssb      = b.ssb;
        adv_i    = CP_W'(b.adv);
    endtask

    task automatic apply_reset(input int idx);
        drive_idle();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk($sformatf("vec%0d reset data", idx), 64'(m_tdata), 64'(0));
        chk($sformatf("vec%0d reset ctl", idx), 64'({m_tuser, m_tvalid, m_tlast, trunc, jfwd, jbwd}), 64'(0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Input stream: symbols of cp_len+FFT_LEN beats; one may be cut short by tlast, one cut off by an SSB.
    task automatic build(input vec_t t);
        int    advj, a, skip, len;
        bit    pend_ssb;
        logic [META_W-1:0] m;
        beat_t b;
        beats.delete();
        pend_ssb = 1'b0;
        for (int j = 0; j < t.nsym; j++) begin
            advj = (j == 0) ? t.adv_a : t.adv_b;
            a    = (advj > t.cp_len) ? t.cp_len : advj;
            skip = t.cp_len - a;
            len  = t.cp_len + FFT_LEN;
            if (j == t.trunc_sym) len = skip + t.trunc_len + 1;
            if (j == t.ssb_sym)   len = t.ssb_off;
            m = META_W'($urandom);
            for (int k = 0; k < len; k++) begin
                b.data   = {IN_DW'(32'h8000_0000 + 3 * beats.size()), IN_DW'(32'h1000_0000 + beats.size())};
                b.meta   = m;
                b.cp_len = t.cp_len;
                b.adv    = advj;
                b.tlast  = (k == len - 1) && (j != t.ssb_sym);
                b.ssb    = (k == 0) && pend_ssb;
                beats.push_back(b);
            end
            pend_ssb = (j == t.ssb_sym);
        end
    endtask

    // Reference: walk symbols as index intervals [start, tlast]; window = [start+skip, +FFT_LEN-1] cut at tlast.
    task automatic model();
        int n, s, L, a, skip, ws, we, e, found;
        n  = beats.size();
        ex = new[n];
        for (int i = 0; i < n; i++) begin
            ex[i].v = 0; ex[i].last = 0; ex[i].trunc = 0; ex[i].fwd = 0; ex[i].bwd = 0; ex[i].tuser = '0;
        end
        s = 0;
        while (s < n) begin
            L    = beats[s].cp_len;
            a    = (beats[s].adv < L) ? beats[s].adv : L;
            skip = L - a;
            ws   = s + skip;
            found = -1;
            for (int q = s + 1; q < ws && q < n; q++) if (beats[q].ssb) begin found = q; break; end
            if (found >= 0) begin
                ex[found].bwd = 1;
                s = found;
                continue;
            end
            e = s;
            while (e < n - 1 && !beats[e].tlast) e++;
            if (ws > e) begin
                s = e + 1;
                continue;
            end
            we = (ws + FFT_LEN - 1 < e) ? ws + FFT_LEN - 1 : e;
            for (int q = ws; q <= we; q++) begin
                ex[q].v     = 1;
                ex[q].tuser = {beats[ws].meta, CP_W'(a)};
            end
            ex[we].last  = 1;
            ex[we].trunc = (we < ws + FFT_LEN - 1);
            found = -1;
            for (int q = we + 1; q < e; q++) if (beats[q].ssb) begin found = q; break; end
            if (found >= 0) begin
                ex[found].fwd = 1;
                s = found;
            end else begin
                s = e + 1;
            end
        end
    endtask

    task automatic chk_opt(input string name, input int act, input int exp);
        if (exp >= 0) chk(name, 64'(act), 64'(exp));
    endtask

    task automatic run_vec(input int idx, input vec_t t);
        int   bi, nwin, ws0, ws1, adv0, adv1, ntr, nfw, nbw;
        bit   gap, in_win;
        exp_t e;
        build(t);
        model();
        apply_reset(idx);
        bi = 0; nwin = 0; ws0 = -1; ws1 = -1; adv0 = -1; adv1 = -1;
        ntr = 0; nfw = 0; nbw = 0; in_win = 0;
        while (bi < beats.size()) begin
            gap = (t.gap_pct > 0) && (int'($urandom_range(99, 0)) < t.gap_pct);
            if (gap) drive_idle();
            else     drive_beat(beats[bi]);
            @(posedge clk);
            #1;
            if (gap) begin
                chk($sformatf("vec%0d gap strobes", idx),
                    64'({m_tvalid, m_tlast, trunc, jfwd, jbwd}), 64'(0));
            end else begin
                e = ex[bi];
                chk($sformatf("vec%0d beat%0d strobes", idx, bi),
                    64'({m_tvalid, m_tlast, trunc, jfwd, jbwd}), 64'({e.v, e.last, e.trunc, e.fwd, e.bwd}));
                if (e.v) begin
                    chk($sformatf("vec%0d beat%0d data", idx, bi), 64'(m_tdata), 64'(beats[bi].data));
                    chk($sformatf("vec%0d beat%0d tuser", idx, bi), 64'(m_tuser), 64'(e.tuser));
                end
            end
            if (m_tvalid) begin
                if (!in_win) begin
                    if (nwin == 0) begin ws0 = bi; adv0 = int'(m_tuser[CP_W-1:0]); end
                    if (nwin == 1) begin ws1 = bi; adv1 = int'(m_tuser[CP_W-1:0]); end
                    in_win = 1;
                end
                if (m_tlast) begin
                    nwin++;
                    in_win = 0;
                end
            end
            ntr += int'(trunc);
            nfw += int'(jfwd);
            nbw += int'(jbwd);
            if (!gap) bi++;
        end
        drive_idle();
        chk_opt($sformatf("vec%0d windows", idx), nwin, t.exp_nwin);
        chk_opt($sformatf("vec%0d win0 start", idx), ws0, t.exp_ws0);
        chk_opt($sformatf("vec%0d win0 adv", idx), adv0, t.exp_adv0);
        chk_opt($sformatf("vec%0d win1 start", idx), ws1, t.exp_ws1);
        chk_opt($sformatf("vec%0d win1 adv", idx), adv1, t.exp_adv1);
        chk_opt($sformatf("vec%0d trunc count", idx), ntr, t.exp_trunc);
        chk_opt($sformatf("vec%0d fwd count", idx), nfw, t.exp_fwd);
        chk_opt($sformatf("vec%0d bwd count", idx), nbw, t.exp_bwd);
    endtask

    initial begin
        // cp adv_a adv_b nsym gap tsym tlen ssym soff | nwin ws0 adv0 ws1 adv1 trunc fwd bwd
        vt[0] = '{18, 9, 9, 3, 0, -1, 0, -1, 0,     3, 9, 9, 283, 9, 0, 0, 0};
        vt[1] = '{20, 0, 25, 2, 0, -1, 0, -1, 0,    2, 20, 0, 276, 20, 0, 0, 0};
        vt[2] = '{18, 4, 4, 3, 50, -1, 0, -1, 0,    3, 14, 4, 288, 4, 0, 0, 0};
        vt[3] = '{18, 9, 9, 2, 0, -1, 0, 0, 269,    2, 9, 9, 278, 9, 0, 1, 0};
        vt[4] = '{18, 9, 9, 3, 0, -1, 0, 0, 5,      2, 14, 9, 288, 9, 0, 0, 1};
        vt[5] = '{18, 9, 9, 3, 0, -1, 0, 1, 0,      2, 9, 9, 283, 9, 0, 0, 0};
        vt[6] = '{18, 9, 9, 2, 0, 0, 100, -1, 0,    2, 9, 9, 119, 9, 1, 0, 0};
        vt[7] = '{18, 9, 9, 2, 40, -1, 0, 0, 269,   2, 9, 9, 278, 9, 0, 1, 0};
        for (int r = 8; r < 11; r++) begin
            vt[r] = '{int'($urandom_range(20, 0)), int'($urandom_range(31, 0)), int'($urandom_range(31, 0)),
                      3, 30, (r == 9) ? 1 : -1, int'($urandom_range(200, 1)), -1, 0,
                      -1, -1, -1, -1, -1, -1, -1, -1};
        end

        rst_n   = 1'b0;
        s_tdata = '0;
        s_tuser = '0;
        adv_i   = '0;
        drive_idle();
        #12;
        chk("initial reset ctl", 64'({m_tuser, m_tvalid, m_tlast, trunc, jfwd, jbwd}), 64'(0));
        chk("initial reset data", 64'(m_tdata), 64'(0));

        // Reset asserted inside a running window clears every output immediately.
        build(vt[0]);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 30; i++) begin
            drive_beat(beats[i]);
            @(posedge clk);
            #1;
        end
        chk("pre-reset valid", 64'(m_tvalid), 64'(1));
        chk("pre-reset data", 64'(m_tdata), 64'(beats[29].data));
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid-window reset ctl", 64'({m_tuser, m_tvalid, m_tlast, trunc, jfwd, jbwd}), 64'(0));
        chk("mid-window reset data", 64'(m_tdata), 64'(0));
        drive_idle();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post-reset idle", 64'({m_tvalid, m_tlast}), 64'(0));

        for (int i = 0; i < 11; i++) run_vec(i, vt[i]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
